stream_demux_1_4: RTL and testbench

STREAM_DEMUX_1_4 -- requirements
Module: stream_demux_1_4

---
 rtl/stream_demux_pkg.sv | 30 +++
 rtl/stream_demux_1_4_slot.sv | 73 +++++++
 rtl/stream_demux_1_4.sv | 49 ++++
 tb/tb_stream_demux_1_4.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants, the channel-select type and small helpers for the 1-to-4 stream demux.
// The optional delivered-word counters are enabled by defining STREAM_DEMUX_STATS_EN.
package stream_demux_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef logic [SEL_W-1:0] ch_sel_t;

    // One-hot decode of a channel number.
    function automatic logic [N_CH-1:0] sel_decode(input ch_sel_t sel);
        logic [N_CH-1:0] onehot;
        onehot      = '0;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] nxt;
        if (cnt == {CNT_W{1'b1}}) begin
            nxt = cnt;
        end else begin
            nxt = cnt + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/stream_demux_1_4_slot.sv
// One-entry channel buffer for the stream demux: full flag, payload register and,
// when STREAM_DEMUX_STATS_EN is defined, a saturating count of drained words.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill_i,
    input  logic [W-1:0]     fill_data_i,
    input  logic             drain_ready_i,
    output logic             full_o,
    output logic [W-1:0]     data_o
`ifdef STREAM_DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] count_o
`endif
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;
    logic         drain;

    assign drain = full_q & drain_ready_i;

    // A fill wins over a drain in the same cycle, so back-to-back words stream through.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (fill_i) begin
            full_d = 1'b1;
            data_d = fill_data_i;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

`ifdef STREAM_DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (drain) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
`endif

endmodule

// File: rtl/stream_demux_1_4.sv
// 1-to-4 valid/ready stream demux with a one-entry buffer per channel.
// Defining STREAM_DEMUX_STATS_EN adds the per-channel dn_count port.
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  up_valid,
    input  logic [W-1:0]          up_data,
    input  ch_sel_t               up_sel,
    output logic                  up_ready,
    output logic [N_CH-1:0]       dn_valid,
    output logic [N_CH*W-1:0]     dn_data,
    input  logic [N_CH-1:0]       dn_ready
`ifdef STREAM_DEMUX_STATS_EN
    ,
    output logic [N_CH*CNT_W-1:0] dn_count
`endif
);

    logic            accept;
    logic [N_CH-1:0] fill;

    // The addressed slot can take a word if it is empty or is being emptied this cycle.
    assign up_ready = ~dn_valid[up_sel] | dn_ready[up_sel];
    assign accept   = up_valid & up_ready;
    assign fill     = accept ? sel_decode(up_sel) : '0;

    for (genvar g = 0; g < N_CH; g++) begin : g_slot
        demux_slot #(
            .W(W)
        ) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .fill_i       (fill[g]),
            .fill_data_i  (up_data),
            .drain_ready_i(dn_ready[g]),
            .full_o       (dn_valid[g]),
            .data_o       (dn_data[g*W +: W])
`ifdef STREAM_DEMUX_STATS_EN
            ,
            .count_o      (dn_count[g*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Randomised and directed bench for stream_demux_1_4 against a queue-based channel model.
// Counter checks are compiled in when STREAM_DEMUX_STATS_EN is defined.
module tb_stream_demux_1_4;
    import stream_demux_pkg::*;

    localparam int W = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  up_valid;
    logic [W-1:0]          up_data;
    ch_sel_t               up_sel;
    logic                  up_ready;
    logic [N_CH-1:0]       dn_valid;
    logic [N_CH*W-1:0]     dn_data;
    logic [N_CH-1:0]       dn_ready;
`ifdef STREAM_DEMUX_STATS_EN
    logic [N_CH*CNT_W-1:0] dn_count;
`endif

    stream_demux_1_4 #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .up_valid(up_valid),
        .up_data (up_data),
        .up_sel  (up_sel),
        .up_ready(up_ready),
        .dn_valid(dn_valid),
        .dn_data (dn_data),
        .dn_ready(dn_ready)
`ifdef STREAM_DEMUX_STATS_EN
        ,
        .dn_count(dn_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Channel model: each channel is a FIFO of capacity one, plus the last word written
    // (the payload register keeps it after the word is taken) and a delivered count.
    logic [W-1:0] mq[N_CH][$];
    logic [W-1:0] mlast[N_CH];
    int           mcnt[N_CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N_CH; i++) begin
            mq[i].delete();
            mlast[i] = '0;
            mcnt[i]  = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N_CH-1:0]   ev;
        logic [N_CH*W-1:0] ed;
        for (int i = 0; i < N_CH; i++) begin
            ev[i]         = (mq[i].size() != 0);
            ed[i*W +: W]  = mlast[i];
        end
        chk({tag, "_valid"}, 32'(dn_valid), 32'(ev));
        chk({tag, "_data"}, 32'(dn_data), 32'(ed));
`ifdef STREAM_DEMUX_STATS_EN
        for (int i = 0; i < N_CH; i++) begin
            chk({tag, "_count"}, 32'(dn_count[i*CNT_W +: CNT_W]), 32'(mcnt[i]));
        end
`endif
    endtask

    // One clock cycle: drive inputs away from the edge, check the combinational ready,
    // advance the model across the edge, then check the registered outputs.
    task automatic step(input logic v, input ch_sel_t s, input logic [W-1:0] d,
                        input logic [N_CH-1:0] r, input string tag);
        logic exp_ready;
        @(negedge clk);
        up_valid = v;
        up_sel   = s;
        up_data  = d;
        dn_ready = r;
        #1;
        exp_ready = (mq[s].size() == 0) || r[s];
        chk({tag, "_up_ready"}, 32'(up_ready), 32'(exp_ready));
        @(posedge clk);
        for (int i = 0; i < N_CH; i++) begin
            if (mq[i].size() != 0 && r[i]) begin
                void'(mq[i].pop_front());
                if (mcnt[i] < 255) mcnt[i]++;
            end
        end
        if (v && exp_ready) begin
            mq[s].push_back(d);
            mlast[s] = d;
        end
        #1;
        check_outputs(tag);
    endtask

    // Reset pulsed between edges while an upstream word is offered across a clock edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        up_valid = 1'b1;
        up_sel   = 2'd1;
        up_data  = 4'h7;
        dn_ready = '0;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk({tag, "_async_valid"}, 32'(dn_valid), 32'h0);
        chk({tag, "_async_data"}, 32'(dn_data), 32'h0);
        chk({tag, "_rst_ready"}, 32'(up_ready), 32'h1);
        @(posedge clk);
        #1;
        chk({tag, "_no_xfer_in_rst"}, 32'(dn_valid), 32'h0);
        @(negedge clk);
        up_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check_outputs({tag, "_post"});
    endtask

    initial begin
        rst_n    = 1'b0;
        up_valid = 1'b0;
        up_sel   = '0;
        up_data  = '0;
        dn_ready = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(dn_valid), 32'h0);
        chk("reset_data", 32'(dn_data), 32'h0);
        chk("reset_ready", 32'(up_ready), 32'h1);
`ifdef STREAM_DEMUX_STATS_EN
        chk("reset_count", 32'(dn_count), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Single word to channel 2, then ready depends on the addressed slot.
        step(1'b1, 2'd2, 4'hA, 4'b0000, "single");
        chk("single_valid_const", 32'(dn_valid), 32'h4);
        chk("single_slice2", 32'(dn_data[2*W +: W]), 32'hA);
        up_valid = 1'b0;
        up_sel   = 2'd2;
        #1;
        chk("single_rdy_sel2", 32'(up_ready), 32'h0);
        up_sel = 2'd0;
        #1;
        chk("single_rdy_sel0", 32'(up_ready), 32'h1);

        // Full throughput into channel 1 with its consumer always ready.
        pulse_reset("rst_a");
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 2'd1, 4'(k), 4'b0010, "stream");
            chk("stream_v1", 32'(dn_valid[1]), 32'h1);
            chk("stream_d1", 32'(dn_data[1*W +: W]), 32'(k));
        end
        step(1'b0, 2'd1, 4'h0, 4'b0010, "stream_tail");

        // All four slots full, then drain channels 0 and 2 only.
        pulse_reset("rst_b");
        for (int k = 0; k < N_CH; k++) begin
            step(1'b1, ch_sel_t'(k), 4'(k), 4'b0000, "fill");
        end
        chk("fill_all_valid", 32'(dn_valid), 32'hF);
        for (int k = 0; k < N_CH; k++) begin
            up_sel = ch_sel_t'(k);
            #1;
            chk("fill_all_blocked", 32'(up_ready), 32'h0);
        end
        step(1'b0, 2'd0, 4'h0, 4'b0101, "part_drain");
        chk("part_drain_const", 32'(dn_valid), 32'hA);

        // Slots 0 and 3 full, asynchronous reset wipes them, then one word to channel 3.
        step(1'b1, 2'd0, 4'h5, 4'b0000, "pre_rst0");
        step(1'b1, 2'd3, 4'h9, 4'b0000, "pre_rst3");
        pulse_reset("rst_c");
        step(1'b1, 2'd3, 4'hC, 4'b0000, "post_rst");
        chk("post_rst_only3", 32'(dn_valid), 32'h8);

        // Idle upstream with wiggling select and payload must not fill anything.
        pulse_reset("rst_d");
        for (int k = 0; k < 20; k++) begin
            step(1'b0, ch_sel_t'($urandom_range(3)), 4'($urandom), 4'($urandom), "idle");
        end
        chk("idle_empty", 32'(dn_valid), 32'h0);

`ifdef STREAM_DEMUX_STATS_EN
        // Long run into channel 0 to reach the counter ceiling.
        pulse_reset("rst_e");
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 2'd0, 4'($urandom), 4'b0001, "sat");
        end
        chk("sat_cnt0", 32'(dn_count[0 +: CNT_W]), 32'd255);
        chk("sat_others", 32'(dn_count[CNT_W +: 3*CNT_W]), 32'h0);
`endif

        // Randomised traffic against the model.
        pulse_reset("rst_f");
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom), ch_sel_t'($urandom_range(3)), 4'($urandom), 4'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
